// File: rtl/data_memory_responder.sv
// data_memory_responder
//
// Responder side of the data-memory interface used by the memory-access stage.
// It takes one load or store at a time over a valid/ready handshake. Each
// request then goes through a single ACCESS cycle against an internal array of
// XLEN-wide rows. The result comes back over a second valid/ready handshake.
// Store bytes are written only to the lanes that the size and address select.
// Load data is returned right-aligned and zero-filled. Misaligned requests,
// out-of-range requests and illegal sizes return an error and never touch
// the array.
//
// Ports:
//   clk, rst    clock (rising edge) and asynchronous active-high reset
//   req_valid   request present           req_ready  high only in IDLE
//   req_write   1 = store, 0 = load       req_addr   byte address
//   req_size    00 byte .. 11 doubleword  req_wdata  store data, right-aligned
//   rsp_valid   response present          rsp_ready  requester takes response
//   rsp_rdata   load data (0 for stores and errors)
//   rsp_write   echo of req_write         rsp_error  request was rejected
module data_memory_responder #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 256
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [XLEN-1:0] req_addr,
  input  logic [1:0]      req_size,
  input  logic [XLEN-1:0] req_wdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_write,
  output logic            rsp_error
);

  localparam int LANES = XLEN / 8;
  localparam int LB    = $clog2(LANES);
  localparam int RB    = $clog2(DEPTH);
  localparam int AW    = LB + RB;

  typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_t;

  state_t            state_q, state_d;
  logic              write_q, write_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [1:0]        size_q, size_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic              err_q, err_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic              rsp_write_q, rsp_write_d;
  logic              rsp_error_q, rsp_error_d;

  logic [XLEN-1:0]   mem [DEPTH];

  logic              req_err;
  logic [XLEN-1:0]   align_mask;
  logic [LB-1:0]     lane;
  logic [RB-1:0]     row_idx;
  logic [LANES-1:0]  size_bytes;
  logic [LANES-1:0]  lane_mask;
  logic [XLEN-1:0]   data_mask;
  logic [XLEN-1:0]   wshift;
  logic [XLEN-1:0]   rdata_access;
  logic              mem_we;

  // Error classification is done on the incoming request. Only the flag is
  // kept, so the upper address bits never need to be stored.
  always_comb begin
    align_mask = (XLEN'(1) << req_size) - XLEN'(1);
    req_err    = 1'b0;
    if (|(req_addr & align_mask)) req_err = 1'b1;
    if (|(req_addr >> AW))        req_err = 1'b1;
    if ((XLEN == 32) && (req_size == 2'b11)) req_err = 1'b1;
  end

  // The byte mask covers the low 2^size bytes. It is shifted up to the
  // addressed lane for stores, and it masks the shifted row for loads.
  always_comb begin
    lane    = addr_q[LB-1:0];
    row_idx = addr_q[LB +: RB];
    for (int b = 0; b < LANES; b++) begin
      size_bytes[b]       = (b < (1 << size_q));
      data_mask[8*b +: 8] = {8{size_bytes[b]}};
    end
    lane_mask    = size_bytes << lane;
    wshift       = wdata_q << {lane, 3'b000};
    rdata_access = (mem[row_idx] >> {lane, 3'b000}) & data_mask;
    // The store is suppressed at an edge where rst is high, so a reset that
    // lands during ACCESS never commits a partial store.
    mem_we       = (state_q == ACCESS) && write_q && !err_q && !rst;
  end

  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    addr_d      = addr_q;
    size_d      = size_q;
    wdata_d     = wdata_q;
    err_d       = err_q;
    rdata_d     = rdata_q;
    rsp_write_d = rsp_write_q;
    rsp_error_d = rsp_error_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          addr_d  = req_addr[AW-1:0];
          size_d  = req_size;
          wdata_d = req_wdata;
          err_d   = req_err;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        rdata_d     = (!write_q && !err_q) ? rdata_access : '0;
        rsp_write_d = write_q;
        rsp_error_d = err_q;
        state_d     = RESPOND;
      end
      RESPOND: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      write_q     <= 1'b0;
      addr_q      <= '0;
      size_q      <= '0;
      wdata_q     <= '0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      rsp_write_q <= 1'b0;
      rsp_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      size_q      <= size_d;
      wdata_q     <= wdata_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      rsp_write_q <= rsp_write_d;
      rsp_error_q <= rsp_error_d;
    end
  end

  // The array has no reset, so its contents survive rst.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < LANES; b++) begin
        if (lane_mask[b]) mem[row_idx][8*b +: 8] <= wshift[8*b +: 8];
      end
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESPOND);
  assign rsp_rdata = rdata_q;
  assign rsp_write = rsp_write_q;
  assign rsp_error = rsp_error_q;

endmodule

// File: tb/tb_data_memory_responder.sv
// tb_data_memory_responder
//
// Directed bench for data_memory_responder (XLEN=64, DEPTH=256). Inputs are
// driven 1ns after each rising edge, and outputs are sampled at that same
// point.
module tb_data_memory_responder;

   logic        clk;
   logic        rst;
   logic        reqValid;
   logic        reqReady;
   logic        reqWrite;
   logic [63:0] reqAddr;
   logic [1:0]  reqSize;
   logic [63:0] reqWdata;
   logic        rspValid;
   logic        rspReady;
   logic [63:0] rspRdata;
   logic        rspWrite;
   logic        rspError;

   int checks = 0;
   int errors = 0;

   data_memory_responder #(.XLEN(64), .DEPTH(256)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (reqValid),
      .req_ready (reqReady),
      .req_write (reqWrite),
      .req_addr  (reqAddr),
      .req_size  (reqSize),
      .req_wdata (reqWdata),
      .rsp_valid (rspValid),
      .rsp_ready (rspReady),
      .rsp_rdata (rspRdata),
      .rsp_write (rspWrite),
      .rsp_error (rspError)
   );

   // 10ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One comparison: counts it and reports any difference
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Full transaction with rsp_ready driven high as soon as the response shows
   task automatic applyStimulus(input string tag, input logic wr, input logic [63:0] addr,
                                input logic [1:0] size, input logic [63:0] wdata,
                                input logic [63:0] expData, input logic expErr);
      checkOutput({tag, "_req_ready"}, 64'(reqReady), 64'd1);
      reqValid = 1'b1;
      reqWrite = wr;
      reqAddr  = addr;
      reqSize  = size;
      reqWdata = wdata;
      @(posedge clk); #1;
      reqValid = 1'b0;
      checkOutput({tag, "_access_valid"}, 64'(rspValid), 64'd0);
      @(posedge clk); #1;
      checkOutput({tag, "_rsp_valid"}, 64'(rspValid), 64'd1);
      checkOutput({tag, "_rdata"}, rspRdata, expData);
      checkOutput({tag, "_error"}, 64'(rspError), 64'(expErr));
      checkOutput({tag, "_write"}, 64'(rspWrite), 64'(wr));
      rspReady = 1'b1;
      @(posedge clk); #1;
      rspReady = 1'b0;
      checkOutput({tag, "_done_valid"}, 64'(rspValid), 64'd0);
   endtask

   logic [63:0] b2bExp [3];
   logic        acc;
   logic        hs;
   int          k;

   initial begin
      rst      = 1'b1;
      reqValid = 1'b0;
      reqWrite = 1'b0;
      reqAddr  = '0;
      reqSize  = '0;
      reqWdata = '0;
      rspReady = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_req_ready", 64'(reqReady), 64'd1);
      checkOutput("rst_rsp_valid", 64'(rspValid), 64'd0);
      checkOutput("rst_rsp_rdata", rspRdata, 64'd0);
      checkOutput("rst_rsp_write", 64'(rspWrite), 64'd0);
      checkOutput("rst_rsp_error", 64'(rspError), 64'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Lane-aligned loads from one stored doubleword
      applyStimulus("st_d10", 1'b1, 64'h10, 2'b11, 64'h1122334455667788, 64'h0, 1'b0);
      applyStimulus("ld_b13", 1'b0, 64'h13, 2'b00, 64'h0, 64'h55, 1'b0);
      applyStimulus("ld_h12", 1'b0, 64'h12, 2'b01, 64'h0, 64'h5566, 1'b0);
      applyStimulus("ld_w14", 1'b0, 64'h14, 2'b10, 64'h0, 64'h11223344, 1'b0);

      // Byte store preserves neighbouring lanes
      applyStimulus("st_b15", 1'b1, 64'h15, 2'b00, 64'hAB, 64'h0, 1'b0);
      applyStimulus("ld_d10", 1'b0, 64'h10, 2'b11, 64'h0, 64'h1122AB4455667788, 1'b0);

      // Rejected requests
      applyStimulus("ld_w06_mis", 1'b0, 64'h6, 2'b10, 64'h0, 64'h0, 1'b1);
      applyStimulus("ld_oor", 1'b0, 64'h800, 2'b00, 64'h0, 64'h0, 1'b1);
      applyStimulus("st_h11_mis", 1'b1, 64'h11, 2'b01, 64'hFFFF, 64'h0, 1'b1);
      applyStimulus("ld_d10_keep", 1'b0, 64'h10, 2'b11, 64'h0, 64'h1122AB4455667788, 1'b0);

      // Stall in RESPOND with a new request waiting, then release
      reqValid = 1'b1;
      reqWrite = 1'b0;
      reqAddr  = 64'h10;
      reqSize  = 2'b11;
      @(posedge clk); #1;
      reqValid = 1'b0;
      @(posedge clk); #1;
      reqValid = 1'b1;
      reqAddr  = 64'h17;
      reqSize  = 2'b00;
      for (int i = 0; i < 5; i++) begin
         checkOutput($sformatf("stall%0d_valid", i), 64'(rspValid), 64'd1);
         checkOutput($sformatf("stall%0d_rdata", i), rspRdata, 64'h1122AB4455667788);
         checkOutput($sformatf("stall%0d_req_ready", i), 64'(reqReady), 64'd0);
         @(posedge clk); #1;
      end
      rspReady = 1'b1;
      checkOutput("release_req_ready", 64'(reqReady), 64'd0);
      @(posedge clk); #1;
      rspReady = 1'b0;
      checkOutput("release_valid", 64'(rspValid), 64'd0);
      checkOutput("release_idle", 64'(reqReady), 64'd1);
      @(posedge clk); #1;
      reqValid = 1'b0;
      checkOutput("held_req_access", 64'(reqReady), 64'd0);
      @(posedge clk); #1;
      checkOutput("held_req_valid", 64'(rspValid), 64'd1);
      checkOutput("held_req_rdata", rspRdata, 64'h11);
      rspReady = 1'b1;
      @(posedge clk); #1;
      rspReady = 1'b0;

      // Reset during ACCESS of a store must not commit it
      applyStimulus("st_d20_zero", 1'b1, 64'h20, 2'b11, 64'h0, 64'h0, 1'b0);
      applyStimulus("ld_d10_pre", 1'b0, 64'h10, 2'b11, 64'h0, 64'h1122AB4455667788, 1'b0);
      reqValid = 1'b1;
      reqWrite = 1'b1;
      reqAddr  = 64'h20;
      reqSize  = 2'b00;
      reqWdata = 64'hFF;
      @(posedge clk); #1;
      reqValid = 1'b0;
      rst = 1'b1;
      #1;
      checkOutput("rstacc_req_ready", 64'(reqReady), 64'd1);
      checkOutput("rstacc_rsp_valid", 64'(rspValid), 64'd0);
      checkOutput("rstacc_rsp_rdata", rspRdata, 64'd0);
      checkOutput("rstacc_rsp_error", 64'(rspError), 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      applyStimulus("ld_d20_after_rst", 1'b0, 64'h20, 2'b11, 64'h0, 64'h0, 1'b0);

      // Back-to-back loads with rsp_ready held high
      b2bExp[0] = 64'h88;
      b2bExp[1] = 64'h77;
      b2bExp[2] = 64'h66;
      k        = 0;
      reqValid = 1'b1;
      reqWrite = 1'b0;
      reqAddr  = 64'h10;
      reqSize  = 2'b00;
      rspReady = 1'b1;
      for (int i = 0; i < 9; i++) begin
         acc = reqValid && reqReady;
         hs  = rspValid && rspReady;
         checkOutput($sformatf("b2b%0d_accept", i), 64'(acc), 64'((i % 3) == 0));
         checkOutput($sformatf("b2b%0d_rsp", i), 64'(hs), 64'((i % 3) == 2));
         if (hs && k < 3) begin
            checkOutput($sformatf("b2b%0d_rdata", i), rspRdata, b2bExp[k]);
            k++;
         end
         @(posedge clk); #1;
         if (acc) begin
            if (i == 6) reqValid = 1'b0;
            else reqAddr = reqAddr + 64'd1;
         end
      end
      rspReady = 1'b0;
      checkOutput("b2b_rsp_count", 64'(k), 64'd3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
